// File: rtl/sar_mag_search_if.sv
// Operand-side bus between the SAR search controller and a magnitude comparator,
// plus the search control/status signals.
interface sar_mag_search_if #(parameter int WIDTH = 3);
    logic             start;
    logic [WIDTH-1:0] probe;
    logic             greater;
    logic             equal;
    logic             lower;
    logic             busy;
    logic             done;
    logic             found;
    logic             error;
    logic [WIDTH-1:0] result;
    logic [3:0]       compares;

    modport master (
        input  start, greater, equal, lower,
        output probe, busy, done, found, error, result, compares
    );

    modport slave (
        output start, greater, equal, lower,
        input  probe, busy, done, found, error, result, compares
    );
endinterface

// File: rtl/sar_mag_search.sv
// Successive-approximation controller that binary-searches a comparator's hidden
// operand by driving the probe operand and reading the greater/equal/lower flags.
module sar_mag_search #(
    parameter int WIDTH  = 3,
    parameter int SETTLE = 1
) (
    input logic              clk,
    input logic              rst,
    sar_mag_search_if.master bus
);
    localparam int CW = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);
    localparam logic [WIDTH:0]  TOP        = {1'b0, {WIDTH{1'b1}}};
    localparam logic [CW-1:0]   SETTLE_VAL = CW'(SETTLE);

    typedef enum logic [1:0] {IDLE, SEARCH, FINISH} state_t;

    state_t           state, state_n;
    logic [WIDTH:0]   lo, lo_n, hi, hi_n;
    logic [WIDTH-1:0] probe, probe_n, result, result_n;
    logic [CW-1:0]    settle, settle_n;
    logic             found, found_n, error, error_n;
    logic [3:0]       compares, compares_n;
    logic             step;
    logic             exhausted;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            lo       <= '0;
            hi       <= '0;
            probe    <= '0;
            result   <= '0;
            settle   <= '0;
            found    <= 1'b0;
            error    <= 1'b0;
            compares <= '0;
        end else begin
            state    <= state_n;
            lo       <= lo_n;
            hi       <= hi_n;
            probe    <= probe_n;
            result   <= result_n;
            settle   <= settle_n;
            found    <= found_n;
            error    <= error_n;
            compares <= compares_n;
        end
    end

    // lo is never negative but hi may reach -1; zero-extending lo keeps lo=2^WIDTH positive.
    assign exhausted = $signed({1'b0, lo_n}) > $signed({hi_n[WIDTH], hi_n});

    always_comb begin
        state_n    = state;
        lo_n       = lo;
        hi_n       = hi;
        probe_n    = probe;
        result_n   = result;
        settle_n   = settle;
        found_n    = found;
        error_n    = error;
        compares_n = compares;
        step       = 1'b0;

        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_n    = SEARCH;
                    lo_n       = '0;
                    hi_n       = TOP;
                    probe_n    = TOP[WIDTH:1];
                    settle_n   = SETTLE_VAL;
                    compares_n = '0;
                    found_n    = 1'b0;
                    error_n    = 1'b0;
                end
            end
            SEARCH: begin
                settle_n = settle - CW'(1);
                if (settle == CW'(1)) begin
                    compares_n = (compares == 4'd15) ? compares : compares + 4'd1;
                    case ({bus.greater, bus.equal, bus.lower})
                        3'b010: begin
                            result_n = probe;
                            found_n  = 1'b1;
                            state_n  = FINISH;
                        end
                        3'b100: begin
                            lo_n = {1'b0, probe} + 1'b1;
                            step = 1'b1;
                        end
                        3'b001: begin
                            hi_n = {1'b0, probe} - 1'b1;
                            step = 1'b1;
                        end
                        default: begin
                            error_n = 1'b1;
                            found_n = 1'b0;
                            state_n = FINISH;
                        end
                    endcase
                    if (step) begin
                        if (exhausted) begin
                            state_n = FINISH;
                        end else begin
                            probe_n  = WIDTH'((lo_n + hi_n) >> 1);
                            settle_n = SETTLE_VAL;
                        end
                    end
                end
            end
            FINISH: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign bus.probe    = probe;
    assign bus.busy     = (state == SEARCH);
    assign bus.done     = (state == FINISH);
    assign bus.found    = found;
    assign bus.error    = error;
    assign bus.result   = result;
    assign bus.compares = compares;
endmodule

// File: tb/tb_sar_mag_search.sv
// Scoreboard bench for sar_mag_search: one SETTLE=1 instance with a combinational
// comparator model and one SETTLE=3 instance with a one-cycle registered comparator.
module tb_sar_mag_search;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sar_mag_search_if #(.WIDTH(3)) bus1();
    sar_mag_search_if #(.WIDTH(3)) bus3();

    sar_mag_search #(.WIDTH(3), .SETTLE(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    sar_mag_search #(.WIDTH(3), .SETTLE(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

    typedef struct {
        bit         found;
        bit         error;
        logic [2:0] result;
        int         compares;
        logic [2:0] probe;
        int         latency;
    } exp_t;

    exp_t q1[$];
    exp_t q3[$];
    exp_t e1, e3;

    int total = 0;
    int bad = 0;
    int edge_cnt = 0;
    int start_edge1 = 0;
    int start_edge3 = 0;

    // mode: 0 honest comparator, 2 always lower, 3 greater+lower, 4 no flags
    int         mode1 = 0;
    logic [2:0] target1 = '0;
    logic [2:0] target3 = '0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    always_comb begin
        bus1.greater = 1'b0;
        bus1.equal   = 1'b0;
        bus1.lower   = 1'b0;
        case (mode1)
            0: begin
                bus1.greater = target1 > bus1.probe;
                bus1.equal   = target1 == bus1.probe;
                bus1.lower   = target1 < bus1.probe;
            end
            2: bus1.lower = 1'b1;
            3: begin
                bus1.greater = 1'b1;
                bus1.lower   = 1'b1;
            end
            default: ;
        endcase
    end

    always @(posedge clk) begin
        bus3.greater <= target3 > bus3.probe;
        bus3.equal   <= target3 == bus3.probe;
        bus3.lower   <= target3 < bus3.probe;
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic checkDone(input string tag, input exp_t e, input logic f, input logic err,
                             input logic [2:0] r, input logic [3:0] c, input logic [2:0] p,
                             input int lat);
        checkOutput({tag, " found"}, int'(f), int'(e.found));
        checkOutput({tag, " error"}, int'(err), int'(e.error));
        if (e.found) checkOutput({tag, " result"}, int'(r), int'(e.result));
        checkOutput({tag, " compares"}, int'(c), e.compares);
        checkOutput({tag, " probe"}, int'(p), int'(e.probe));
        checkOutput({tag, " latency"}, lat, e.latency);
    endtask

    // Monitors pop an expectation whenever a done pulse appears.
    always @(negedge clk) begin
        if (!rst && bus1.done === 1'b1) begin
            if (q1.size() == 0) begin
                checkOutput("dut1 unexpected done", 1, 0);
            end else begin
                e1 = q1.pop_front();
                checkDone("dut1", e1, bus1.found, bus1.error, bus1.result, bus1.compares,
                          bus1.probe, edge_cnt - start_edge1);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && bus3.done === 1'b1) begin
            if (q3.size() == 0) begin
                checkOutput("dut3 unexpected done", 1, 0);
            end else begin
                e3 = q3.pop_front();
                checkDone("dut3", e3, bus3.found, bus3.error, bus3.result, bus3.compares,
                          bus3.probe, edge_cnt - start_edge3);
            end
        end
    end

    task automatic launch(input int inst, input exp_t e);
        @(negedge clk);
        if (inst == 1) begin
            q1.push_back(e);
            start_edge1 = edge_cnt;
            bus1.start = 1'b1;
        end else begin
            q3.push_back(e);
            start_edge3 = edge_cnt;
            bus3.start = 1'b1;
        end
        @(negedge clk);
        bus1.start = 1'b0;
        bus3.start = 1'b0;
    endtask

    task automatic waitDone(input string name);
        bit drained = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            #1;
            if (q1.size() == 0 && q3.size() == 0) begin
                drained = 1'b1;
                break;
            end
        end
        if (!drained) begin
            checkOutput({name, " timeout"}, 0, 1);
            q1.delete();
            q3.delete();
        end
        @(negedge clk);
    endtask

    task automatic applyStimulus(input string name, input int inst, input int mode,
                                 input logic [2:0] target, input bit f, input bit err,
                                 input logic [2:0] r, input int c, input logic [2:0] p,
                                 input int lat);
        exp_t e;
        e = '{found: f, error: err, result: r, compares: c, probe: p, latency: lat};
        if (inst == 1) begin
            mode1   = mode;
            target1 = target;
        end else begin
            target3 = target;
        end
        launch(inst, e);
        waitDone(name);
    endtask

    initial begin
        exp_t eb;
        bit   hit;
        rst = 1'b1;
        bus1.start = 1'b0;
        bus3.start = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset probe", int'(bus1.probe), 0);
        checkOutput("reset busy", int'(bus1.busy), 0);
        checkOutput("reset done", int'(bus1.done), 0);
        checkOutput("reset found", int'(bus1.found), 0);
        checkOutput("reset error", int'(bus1.error), 0);
        checkOutput("reset result", int'(bus1.result), 0);
        checkOutput("reset compares", int'(bus1.compares), 0);
        rst = 1'b0;
        @(negedge clk);

        //            name          inst mode tgt found err res cmp probe lat
        applyStimulus("target5",    1,   0,   5,  1,    0,  5,  2,  5,    3);
        applyStimulus("target7",    1,   0,   7,  1,    0,  7,  4,  7,    5);
        applyStimulus("target0",    1,   0,   0,  1,    0,  0,  3,  0,    4);
        applyStimulus("underflow",  1,   2,   0,  0,    0,  0,  3,  0,    4);
        applyStimulus("bad g+l",    1,   3,   0,  0,    1,  0,  1,  3,    2);
        applyStimulus("no flags",   1,   4,   0,  0,    1,  0,  1,  3,    2);
        applyStimulus("settle3 t2", 3,   0,   2,  1,    0,  2,  3,  2,    10);

        // A second start while busy must not disturb the search.
        mode1   = 0;
        target1 = 5;
        eb = '{found: 1'b1, error: 1'b0, result: 3'd5, compares: 2, probe: 3'd5, latency: 3};
        launch(1, eb);
        bus1.start = 1'b1;
        @(negedge clk);
        bus1.start = 1'b0;
        waitDone("busy start");

        // Reset in the middle of a search: outputs clear at once and no done follows.
        target1 = 7;
        @(negedge clk);
        bus1.start = 1'b1;
        @(negedge clk);
        bus1.start = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (bus1.probe == 3'd5) begin
                hit = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checkOutput("midreset saw probe5", int'(hit), 1);
        #2 rst = 1'b1;
        #1;
        checkOutput("midreset probe", int'(bus1.probe), 0);
        checkOutput("midreset busy", int'(bus1.busy), 0);
        checkOutput("midreset compares", int'(bus1.compares), 0);
        checkOutput("midreset found", int'(bus1.found), 0);
        checkOutput("midreset done", int'(bus1.done), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        checkOutput("midreset stays idle", int'(bus1.busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
